// File: rtl/shift_deser_rx.sv
// Serial-to-parallel receiver with a one-entry valid/ready output buffer and sticky error flags.
// Optional even-parity trailer bit: define SHIFT_DESER_PARITY_EN.
module shift_deser_rx #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sin_i,
    input  logic             sin_vld_i,
    input  logic             sof_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic             ovr_err_o,
    output logic             frm_err_o,
`ifdef SHIFT_DESER_PARITY_EN
    output logic             par_err_o,
`endif
    input  logic             err_clr_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               vld_q, vld_d;
    logic               ovr_q, ovr_d;
    logic               frm_q, frm_d;
`ifdef SHIFT_DESER_PARITY_EN
    logic               par_q, par_d;
    logic               par_set;
`endif

    logic               eff_dir;
    logic [WIDTH-1:0]   base;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   word;
    logic               done;
    logic               frm_set;
    logic               ovr_set;

    // A sof bit starts from a clean register so nothing of a dropped partial word leaks through.
    always_comb begin
        eff_dir = (sin_vld_i && sof_i) ? dir_i : dir_q;
        base    = sof_i ? '0 : sr_q;
        shifted = eff_dir ? {base[WIDTH-2:0], sin_i} : {sin_i, base[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        word    = sr_q;
        done    = 1'b0;
        frm_set = 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
        par_set = 1'b0;
`endif
        if (sin_vld_i) begin
            if (sof_i) begin
                frm_set = (state_q != S_IDLE);
                state_d = S_DATA;
                sr_d    = shifted;
                cnt_d   = CNT_W'(1);
                dir_d   = dir_i;
            end else begin
                case (state_q)
                    S_DATA: begin
                        sr_d = shifted;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            cnt_d = '0;
`ifdef SHIFT_DESER_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_IDLE;
                            done    = 1'b1;
                            word    = shifted;
`endif
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
`ifdef SHIFT_DESER_PARITY_EN
                    S_PARITY: begin
                        state_d = S_IDLE;
                        if (^{sr_q, sin_i}) begin
                            par_set = 1'b1;
                        end else begin
                            done = 1'b1;
                            word = sr_q;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Output buffer: a completion while the old word is still held and not taken is an overrun.
    always_comb begin
        vld_d   = vld_q;
        dout_d  = dout_q;
        ovr_set = 1'b0;
        if (vld_q && out_rdy_i) vld_d = 1'b0;
        if (done) begin
            if (vld_q && !out_rdy_i) begin
                ovr_set = 1'b1;
            end else begin
                dout_d = word;
                vld_d  = 1'b1;
            end
        end
        ovr_d = ovr_set | (ovr_q & ~err_clr_i);
        frm_d = frm_set | (frm_q & ~err_clr_i);
`ifdef SHIFT_DESER_PARITY_EN
        par_d = par_set | (par_q & ~err_clr_i);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            frm_q   <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            frm_q   <= frm_d;
`ifdef SHIFT_DESER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign dout_o    = dout_q;
    assign out_vld_o = vld_q;
    assign ovr_err_o = ovr_q;
    assign frm_err_o = frm_q;
`ifdef SHIFT_DESER_PARITY_EN
    assign par_err_o = par_q;
`endif

endmodule

// File: tb/tb_shift_deser_rx.sv
// Bench for shift_deser_rx: frame-level reference model compared every cycle, plus literal checks.
module tb_shift_deser_rx;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sin = 1'b0, sin_vld = 1'b0, sof = 1'b0, dir = 1'b0;
    logic         out_rdy = 1'b0, err_clr = 1'b0;
    logic [W-1:0] dout;
    logic         out_vld, ovr_err, frm_err;
`ifdef SHIFT_DESER_PARITY_EN
    logic         par_err;
`endif

    int checks = 0;
    int errors = 0;

    // Model: the bits of the current frame in arrival order, assembled only when the frame ends.
    int           q[$];
    bit           in_frame, wait_par, fdir;
    bit [W-1:0]   e_dout;
    bit           e_vld, e_ovr, e_frm, e_par;

    shift_deser_rx #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sin_i(sin), .sin_vld_i(sin_vld), .sof_i(sof),
        .dir_i(dir), .dout_o(dout), .out_vld_o(out_vld), .out_rdy_i(out_rdy),
        .ovr_err_o(ovr_err), .frm_err_o(frm_err),
`ifdef SHIFT_DESER_PARITY_EN
        .par_err_o(par_err),
`endif
        .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
        end
    endtask

    function automatic bit [W-1:0] assemble();
        bit [W-1:0] w = '0;
        for (int i = 0; i < W; i++) w[fdir ? (W - 1 - i) : i] = q[i][0];
        return w;
    endfunction

    task automatic model_step();
        bit comp = 0, fs = 0, os = 0, ps = 0, p;
        bit [W-1:0] word = '0;
        if (!rst_n) begin
            q.delete(); in_frame = 0; wait_par = 0; fdir = 0;
            e_dout = '0; e_vld = 0; e_ovr = 0; e_frm = 0; e_par = 0;
            return;
        end
        if (sin_vld) begin
            if (sof) begin
                fs = in_frame;
                q.delete(); q.push_back(int'(sin));
                fdir = dir; in_frame = 1; wait_par = 0;
            end else if (wait_par) begin
                p = sin;
                foreach (q[i]) p ^= q[i][0];
                if (p == 0) begin comp = 1; word = assemble(); end
                else ps = 1;
                in_frame = 0; wait_par = 0; q.delete();
            end else if (in_frame) begin
                q.push_back(int'(sin));
                if (q.size() == W) begin
`ifdef SHIFT_DESER_PARITY_EN
                    wait_par = 1;
`else
                    comp = 1; word = assemble();
                    in_frame = 0; q.delete();
`endif
                end
            end
        end
        if (e_vld && out_rdy) e_vld = 0;
        if (comp) begin
            if (e_vld && !out_rdy) os = 1;
            else begin e_dout = word; e_vld = 1; end
        end
        e_ovr = os | (e_ovr & !err_clr);
        e_frm = fs | (e_frm & !err_clr);
        e_par = ps | (e_par & !err_clr);
    endtask

    task automatic compare();
        chk("dout", 32'(dout), 32'(e_dout));
        chk("out_vld", 32'(out_vld), 32'(e_vld));
        chk("ovr_err", 32'(ovr_err), 32'(e_ovr));
        chk("frm_err", 32'(frm_err), 32'(e_frm));
`ifdef SHIFT_DESER_PARITY_EN
        chk("par_err", 32'(par_err), 32'(e_par));
`endif
    endtask

    // One clock: drive at negedge, step the model at posedge, compare at the following negedge.
    task automatic cyc(input bit s, input bit v, input bit f, input bit d, input bit r, input bit c);
        sin = s; sin_vld = v; sof = f; dir = d; out_rdy = r; err_clr = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // Sends word w in the order implied by d; tog flips dir after the 2nd bit.
    task automatic send_frame(input bit [W-1:0] w, input bit d, input bit r, input bit tog);
        bit dd = d;
        for (int i = 0; i < W; i++) begin
            if (tog && i == 2) dd = ~d;
            cyc(w[d ? (W - 1 - i) : i], 1, i == 0, dd, r, 0);
        end
`ifdef SHIFT_DESER_PARITY_EN
        cyc(^w, 1, 0, dd, r, 0);
`endif
    endtask

    initial begin
        @(negedge clk);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_vld", 32'(out_vld), 32'h0);
        rst_n = 1'b1;
        cyc(1, 1, 0, 0, 0, 0);  // sin_vld without sof in IDLE is ignored
        chk("no_sof_vld", 32'(out_vld), 32'h0);

        send_frame(4'hD, 0, 0, 0);
        chk("lsb_first_dout", 32'(dout), 32'hD);
        chk("lsb_first_vld", 32'(out_vld), 32'h1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("consume_vld", 32'(out_vld), 32'h0);

        send_frame(4'hB, 1, 0, 1);
        chk("msb_first_dir_toggle", 32'(dout), 32'hB);
        cyc(0, 0, 0, 0, 1, 0);

        send_frame(4'h3, 0, 0, 0);
        send_frame(4'hC, 0, 0, 0);
        chk("overrun_keep_dout", 32'(dout), 32'h3);
        chk("overrun_flag", 32'(ovr_err), 32'h1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("err_clr_ovr", 32'(ovr_err), 32'h0);
        cyc(0, 0, 0, 0, 1, 0);

        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        send_frame(4'h6, 0, 0, 0);
        chk("framing_flag", 32'(frm_err), 32'h1);
        chk("framing_dout", 32'(dout), 32'h6);
        cyc(0, 0, 0, 0, 1, 1);

        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        cyc(1, 1, 0, 0, 0, 0);
        chk("midframe_reset_vld", 32'(out_vld), 32'h0);
        rst_n = 1'b1;
        send_frame(4'hA, 0, 0, 0);
        chk("after_reset_dout", 32'(dout), 32'hA);
        chk("after_reset_errs", 32'({ovr_err, frm_err}), 32'h0);
        cyc(0, 0, 0, 0, 1, 0);

`ifdef SHIFT_DESER_PARITY_EN
        cyc(1, 1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("parity_ok_dout", 32'(dout), 32'h3);
        chk("parity_ok_vld", 32'(out_vld), 32'h1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("parity_bad_vld", 32'(out_vld), 32'h0);
        chk("parity_bad_flag", 32'(par_err), 32'h1);
        cyc(0, 0, 0, 0, 0, 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(1, 0), $urandom_range(9, 0) < 7, $urandom_range(19, 0) < 3,
                $urandom_range(1, 0), $urandom_range(9, 0) < 6, $urandom_range(29, 0) == 0);
            if ($urandom_range(499, 0) == 0) begin
                rst_n = 1'b0;
                cyc(0, 0, 0, 0, 0, 0);
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_deser_rx.md
Name: shift_deser_rx

Overview:
- Serial-to-parallel receiver; the capture end of the serial stream produced by our universal shift register shifting out.
- Collects WIDTH bits qualified by a bit strobe, in a selectable bit order.
- Presents each completed word on a one-entry valid/ready output buffer.
- Flags overrun and framing errors with sticky status bits.

Parameters:
- WIDTH, 4, data word width in bits (min 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit.
- sin_vld  input  1  sin is valid this cycle.
- sof  input  1  start of frame; qualified by sin_vld; marks the current bit as bit 0 of a frame.
- dir  input  1  bit order; 0 = LSB first (right shift), 1 = MSB first (left shift).
- dout  output  WIDTH  received word.
- out_vld  output  1  dout holds an unconsumed word.
- out_rdy  input  1  consumer accepts dout when out_vld && out_rdy.
- ovr_err  output  1  sticky overrun flag.
- frm_err  output  1  sticky framing error flag.
- err_clr  input  1  synchronous clear of ovr_err and frm_err.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; shift register and bit counter go to 0.
  - dout=0, out_vld=0, ovr_err=0, frm_err=0.
  - A reset mid-frame discards the partial word.
- States:
  - IDLE: only sin_vld && sof is accepted. It latches dir into dir_q, shifts in sin, sets cnt=1 and moves to DATA. sin_vld without sof is ignored.
  - DATA: each sin_vld shifts in sin and increments cnt.
    - When cnt reaches WIDTH (the WIDTH-th bit), the word is complete and the state returns to IDLE. This holds for WIDTH=2.
    - sin_vld && sof while in DATA: set frm_err, discard the partial word, restart with this bit as bit 0 (cnt=1, dir re-latched) and stay in DATA.
  - PARITY: exists only under the optional feature.
- Shift rules (dir_q is latched at sof; dir changes mid-frame have no effect):
  - dir_q=0: sr <= {sin, sr[WIDTH-1:1]}; the first bit ends at dout[0].
  - dir_q=1: sr <= {sr[WIDTH-2:0], sin}; the first bit ends at dout[WIDTH-1].
- Completion:
  - The completed word is loaded into dout and out_vld=1 on the clock edge that samples the last bit.
  - Visible the cycle after the last sin_vld; latency is 1 clk.
- Output handshake:
  - out_vld && out_rdy clears out_vld on that edge.
  - dout holds its value until the next load; it is not cleared on consume.
- Simultaneous consume and completion: the new word loads, out_vld stays 1, no overrun.
- Overrun: a completion while out_vld=1 and out_rdy=0 drops the NEW word, keeps dout unchanged and sets ovr_err.
- Error flags:
  - err_clr=1 clears both flags.
  - If a set event and err_clr occur in the same cycle, the set wins.
- sin_vld=0 cycles: everything holds; no timeout.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- Defined:
  - After the WIDTH-th data bit, DATA moves to PARITY instead of completing; the assembled word is held.
  - In PARITY, the next sin_vld bit is the even-parity bit: ^{data, bit} must be 0.
  - Match: the word completes under the normal completion and overrun rules.
  - Mismatch: the word is discarded and a par_err output (1 bit, sticky, cleared by err_clr, reset 0) is set.
  - sof in PARITY: frm_err is set and a restart occurs, as in DATA.
- Undefined: no PARITY state, no par_err port; the frame is exactly WIDTH bits.

Test Plan:
- WIDTH=4, dir=0, strobe bits 1,0,1,1 with sof on the first -> next cycle out_vld=1, dout=4'hD; out_rdy=1 then clears out_vld.
- dir=1, same bits 1,0,1,1 -> dout=4'hB. Toggle dir to 0 after the 2nd bit -> dout is still 4'hB.
- out_rdy=0: send frame 4'h3, then frame 4'hC -> dout stays 4'h3, ovr_err=1. Pulse err_clr -> ovr_err=0.
- Send 2 bits of a frame, then a new sof frame 0,1,1,0 (dir=0) -> frm_err=1, dout=4'h6; the partial bits are discarded.
- Assert rst low after 3 bits, release, send a full frame 4'hA -> out_vld=0 during reset, dout=4'hA after, no errors.
- SHIFT_DESER_PARITY_EN defined, dir=0:
  - Data 1,1,0,0 with parity 0 -> dout=4'h3.
  - Data 1,1,0,0 with parity 1 -> out_vld stays 0, par_err=1.
